session_ctrl: RTL
=================

# session_ctrl

Parametrised call-session controller for the FPGA telephony datapath. It sits between the user keypad/decoder and the transport layer and runs call setup and teardown: dial, answer, hang up, busy reply and optional ring timeout. While connected, it buffers microphone samples in an internal FIFO and emits them to transport as fixed-size audio bursts. Received audio words go to the speaker path.

## Interface
Parameters:
- DATA_W, 16, transport word width; must be at least ADDR_W+8
- ADDR_W, 8, phone address width
- DEPTH, 16, mic FIFO depth; power of two, at least PKT_SAMPLES
- PKT_SAMPLES, 4, audio words per outgoing burst
- TIMEOUT, 1000, cycles spent in CALLING/RINGING before abandon

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- phoneNum  in  ADDR_W  dial target, sampled on a dial command
- userInp  in  5  user command: 01 dial, 02 answer, 03 hang up, 00 none
- cmdIn  in  2  transport receive strobe: 00 none, 01 control word, 10 audio word
- packetIn  in  DATA_W  received word; control layout is [7:0] opcode, [ADDR_W+7:8] source address
- transportBusy  in  1  high means transport cannot accept a word this cycle
- mic_valid  in  1  mic sample strobe
- mic_data  in  DATA_W  mic sample
- cmd  out  2  transmit type: 00 idle, 01 control, 10 audio
- dataOut  out  DATA_W  transmit word; control words use the same layout as packetIn, with the address field holding the destination
- phoneOut  out  ADDR_W  current peer address
- sessionBusy  out  1  high when state is not IDLE
- micFlag  out  1  high in CONNECTED
- current_state  out  3  state encoding
- spk_valid  out  1  one-cycle strobe for a received audio word
- spk_data  out  DATA_W  received audio word
- mic_full  out  1  FIFO full
- mic_empty  out  1  FIFO empty
- mic_overflow  out  1  sticky; a sample was dropped because the FIFO was full

## Operation
Opcodes:
- 01 CALL_REQ, 02 ACCEPT, 03 HANGUP, 05 BUSY; any other opcode is ignored.

userInp edge detection:
- A command acts once, on the first cycle that userInp differs from its previous registered value and is nonzero.
- Holding a code has no further effect.

States (current_state encoding):
- IDLE=0:
  - Dial latches phoneNum into phoneOut, queues CALL_REQ to phoneOut, and moves to CALLING.
  - A received CALL_REQ latches its source into phoneOut and moves to RINGING.
- CALLING=1:
  - ACCEPT from phoneOut moves to CONNECTED.
  - BUSY or HANGUP from phoneOut moves to IDLE.
  - User hang up queues HANGUP and moves to IDLE.
- RINGING=2:
  - User answer queues ACCEPT and moves to CONNECTED.
  - User hang up queues HANGUP and moves to IDLE.
  - HANGUP from the caller moves to IDLE.
- CONNECTED=3:
  - User hang up queues HANGUP and moves to HANGUP state.
  - Received HANGUP moves to IDLE.
- HANGUP=4: moves to IDLE once the queued HANGUP word has been transferred.

Control rules:
- A CALL_REQ received in any state other than IDLE queues BUSY to its source; the state does not change.
- Control words from any address other than phoneOut are ignored, except CALL_REQ.
- The control queue is one entry. A new control word overwrites it, except BUSY, which is dropped if the entry is occupied.

Mic FIFO:
- Writes happen only in CONNECTED when mic_valid=1.
- A write while full is dropped and sets mic_overflow; mic_overflow clears on reset or on entering CONNECTED.
- The FIFO is flushed on any exit from CONNECTED.

Transmit arbitration:
- A pending control word wins over audio, but only at a burst boundary.
- An audio burst starts when the FIFO holds at least PKT_SAMPLES words. It emits exactly PKT_SAMPLES words with cmd=10, uninterrupted.

Receive audio:
- cmdIn=10 in CONNECTED produces spk_valid=1 and spk_data=packetIn on the next cycle.
- cmdIn=10 in any other state is ignored.

## Timing
- Reset values: state IDLE, cmd=00, dataOut=0, phoneOut=0, sessionBusy=0, micFlag=0, spk_valid=0, spk_data=0, FIFO empty (mic_empty=1, mic_full=0), mic_overflow=0.
- Reset is honoured mid-burst and mid-handshake; nothing resumes after release.
- Transfer rule: a word transfers on any cycle with cmd≠00 and transportBusy=0.
- While transportBusy=1, cmd and dataOut hold their values unchanged.
- cmd and dataOut are registered. A queued control word appears on the cycle after the triggering event.
- State change: one cycle after the triggering input.
- FIFO: a simultaneous read and write in the same cycle keeps the count unchanged; pointers wrap modulo DEPTH.
- If a state exit and a burst word occur in the same cycle, the burst is aborted: cmd returns to 00, or to 01 if a control word is pending.
- Timeout: with timeout compiled in, the counter clears on entry to CALLING or RINGING. Reaching TIMEOUT-1 moves the block to IDLE; leaving CALLING this way also queues HANGUP.

## Configuration
- SESSION_TIMEOUT_EN defined: timeout counter and transitions present as above.
- SESSION_TIMEOUT_EN undefined: no counter. CALLING and RINGING wait indefinitely; all other behaviour is identical.

## Test plan
- Dial: reset release, phoneNum=8'h20, userInp=01 → next cycle current_state=1, cmd=01, dataOut=16'h2001, phoneOut=8'h20, sessionBusy=1.
- Connect: in CALLING, cmdIn=01, packetIn=16'h2002 → current_state=3, micFlag=1. Then push 4 samples → a 4-word burst with cmd=10, in order.
- Incoming and busy: in IDLE, packetIn=16'h3001 → RINGING with phoneOut=8'h30. A second CALL_REQ packetIn=16'h4001 → dataOut=16'h4005 with cmd=01; state stays RINGING.
- Backpressure: transportBusy=1 mid-burst for 5 cycles → cmd and dataOut frozen; no word lost or duplicated.
- Overflow: CONNECTED with transportBusy=1 and 17 mic_valid strobes (DEPTH=16) → mic_full=1, mic_overflow=1, 16 words retained.
- Timeout, with SESSION_TIMEOUT_EN: CALLING, no reply for 1000 cycles → IDLE plus a HANGUP word 16'h2003. Without the macro: still CALLING after 2000 cycles.

Source files
------------

// File: rtl/session_ctrl.sv
// session_ctrl: call setup/teardown FSM with mic FIFO, audio bursts and a one-entry control queue.
// Optional ring/dial timeout is compiled in with SESSION_TIMEOUT_EN.
module session_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 16,
    parameter int PKT_SAMPLES = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] phoneNum,
    input  logic [4:0]        userInp,
    input  logic [1:0]        cmdIn,
    input  logic [DATA_W-1:0] packetIn,
    input  logic              transportBusy,
    input  logic              mic_valid,
    input  logic [DATA_W-1:0] mic_data,
    output logic [1:0]        cmd,
    output logic [DATA_W-1:0] dataOut,
    output logic [ADDR_W-1:0] phoneOut,
    output logic              sessionBusy,
    output logic              micFlag,
    output logic [2:0]        current_state,
    output logic              spk_valid,
    output logic [DATA_W-1:0] spk_data,
    output logic              mic_full,
    output logic              mic_empty,
    output logic              mic_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(PKT_SAMPLES + 1);
    localparam logic [2:0] IDLE = 3'd0, CALLING = 3'd1, RINGING = 3'd2, CONNECTED = 3'd3, HANGUP = 3'd4;
    localparam logic [7:0] OP_CALL = 8'h01, OP_ACCEPT = 8'h02, OP_HANGUP = 8'h03, OP_BUSY = 8'h05;
    localparam logic [1:0] CMD_IDLE = 2'b00, CMD_CTRL = 2'b01, CMD_AUDIO = 2'b10;

    function automatic logic [DATA_W-1:0] ctrlWordOf(input logic [ADDR_W-1:0] addr, input logic [7:0] op);
        return DATA_W'({addr, op});
    endfunction

    logic [2:0]        state, nextState;
    logic [4:0]        prevInp;
    logic              newCmd, dial, answer, hangUp;
    logic [7:0]        rxOp, peerOp, ctrlOp;
    logic [ADDR_W-1:0] rxSrc;
    logic              rxCall, ctrlReq, busyReq, timeout, sentHangup;
    logic              qValid, qValidNext;
    logic [DATA_W-1:0] qWord, qWordNext;
    logic [BW-1:0]     burstLeft;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr, rdPtr;
    logic [CW-1:0]     count;
    logic              push, pop, exitConn, enterConn, take, loadCtrl, loadAudio;

    assign newCmd     = userInp != prevInp && userInp != 5'd0;
    assign dial       = newCmd && userInp == 5'd1;
    assign answer     = newCmd && userInp == 5'd2;
    assign hangUp     = newCmd && userInp == 5'd3;
    assign rxOp       = packetIn[7:0];
    assign rxSrc      = packetIn[ADDR_W+7:8];
    assign rxCall     = cmdIn == CMD_CTRL && rxOp == OP_CALL;
    assign peerOp     = (cmdIn == CMD_CTRL && rxSrc == phoneOut) ? rxOp : 8'h00;
    assign sentHangup = cmd == CMD_CTRL && !transportBusy && dataOut[7:0] == OP_HANGUP;

    always_comb begin
        nextState = state;
        ctrlReq   = 1'b0;
        ctrlOp    = OP_HANGUP;
        case (state)
            IDLE: begin
                if (dial) begin
                    nextState = CALLING;
                    ctrlReq   = 1'b1;
                    ctrlOp    = OP_CALL;
                end else if (rxCall) nextState = RINGING;
            end
            CALLING: begin
                if (hangUp) begin
                    nextState = IDLE;
                    ctrlReq   = 1'b1;
                end else if (peerOp == OP_ACCEPT) nextState = CONNECTED;
                else if (peerOp == OP_BUSY || peerOp == OP_HANGUP) nextState = IDLE;
                else if (timeout) begin
                    nextState = IDLE;
                    ctrlReq   = 1'b1;
                end
            end
            RINGING: begin
                if (answer) begin
                    nextState = CONNECTED;
                    ctrlReq   = 1'b1;
                    ctrlOp    = OP_ACCEPT;
                end else if (hangUp) begin
                    nextState = IDLE;
                    ctrlReq   = 1'b1;
                end else if (peerOp == OP_HANGUP || timeout) nextState = IDLE;
            end
            CONNECTED: begin
                if (hangUp) begin
                    nextState = HANGUP;
                    ctrlReq   = 1'b1;
                end else if (peerOp == OP_HANGUP) nextState = IDLE;
            end
            HANGUP:  nextState = sentHangup ? IDLE : HANGUP;
            default: nextState = IDLE;
        endcase
    end

    assign exitConn   = state == CONNECTED && nextState != CONNECTED;
    assign enterConn  = state != CONNECTED && nextState == CONNECTED;
    assign busyReq    = rxCall && state != IDLE;
    assign qValidNext = qValid || ctrlReq || busyReq;
    assign qWordNext  = ctrlReq ? ctrlWordOf(state == IDLE ? phoneNum : phoneOut, ctrlOp)
                      : qValid ? qWord : ctrlWordOf(rxSrc, OP_BUSY);
    // An exit from CONNECTED may tear down an audio word even under backpressure.
    assign take       = !transportBusy || (exitConn && cmd == CMD_AUDIO);
    assign loadCtrl   = take && qValidNext && (burstLeft == '0 || exitConn);
    assign loadAudio  = take && !loadCtrl && state == CONNECTED && !exitConn
                      && (burstLeft != '0 || count >= CW'(PKT_SAMPLES));
    assign pop        = loadAudio;
    assign push       = state == CONNECTED && !exitConn && mic_valid && !mic_full;
    assign mic_full   = count == CW'(DEPTH);
    assign mic_empty  = count == '0;

    assign current_state = state;
    assign sessionBusy   = state != IDLE;
    assign micFlag       = state == CONNECTED;

`ifdef SESSION_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;
    logic          waiting;
    assign waiting = state == CALLING || state == RINGING;
    assign timeout = waiting && timer == TW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timer <= '0;
        else timer <= (nextState != state || !waiting) ? '0 : timer + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            prevInp      <= '0;
            phoneOut     <= '0;
            qValid       <= 1'b0;
            qWord        <= '0;
            cmd          <= CMD_IDLE;
            dataOut      <= '0;
            burstLeft    <= '0;
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            mic_overflow <= 1'b0;
            spk_valid    <= 1'b0;
            spk_data     <= '0;
        end else begin
            state   <= nextState;
            prevInp <= userInp;
            if (state == IDLE && nextState == CALLING) phoneOut <= phoneNum;
            else if (state == IDLE && nextState == RINGING) phoneOut <= rxSrc;
            qValid <= qValidNext && !loadCtrl;
            qWord  <= qWordNext;
            if (loadCtrl) begin
                cmd     <= CMD_CTRL;
                dataOut <= qWordNext;
            end else if (loadAudio) begin
                cmd     <= CMD_AUDIO;
                dataOut <= mem[rdPtr];
            end else if (take) begin
                cmd     <= CMD_IDLE;
                dataOut <= '0;
            end
            burstLeft <= exitConn ? '0
                       : loadAudio ? (burstLeft != '0 ? burstLeft - BW'(1) : BW'(PKT_SAMPLES - 1))
                       : burstLeft;
            if (exitConn) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                wrPtr <= wrPtr + AW'(push);
                rdPtr <= rdPtr + AW'(pop);
                count <= count + CW'(push) - CW'(pop);
            end
            if (enterConn) mic_overflow <= 1'b0;
            else if (state == CONNECTED && !exitConn && mic_valid && mic_full) mic_overflow <= 1'b1;
            spk_valid <= state == CONNECTED && cmdIn == CMD_AUDIO;
            if (state == CONNECTED && cmdIn == CMD_AUDIO) spk_data <= packetIn;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= mic_data;
    end
endmodule
